featuremap_streamer: RTL and testbench
======================================

# featuremap_streamer

Frame buffer and raster-order source that feeds a conv2d5x5 feature-map stage. It accepts one input feature map as a burst of pixel writes, holds it, and on `start` replays it as a gap-free `data_out`/`valid_out` stream. The output matches the `data_in`/`valid_in` convention of the convolution instances and can fan out to all of them. Pixel data is opaque to this block; it is stored and replayed bit-exact.

## Interface
- `DATA_WIDTH`, 24, pixel word width.
- `IMG_W`, 12, frame width in pixels (≥1).
- `IMG_H`, 12, frame height in pixels (≥1).
- Derived N = IMG_W*IMG_H, buffer depth; pointer widths are $clog2 of the relevant counts.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe for one pixel, raster order.
- `wr_data`  in  DATA_WIDTH  pixel written when `wr_en`=1.
- `clr`  in  1  discard the stored frame: write pointer := 0, `frame_ready` := 0.
- `start`  in  1  begin replay of the stored frame.
- `data_out`  out  DATA_WIDTH  streamed pixel.
- `valid_out`  out  1  `data_out` valid.
- `done`  out  1  one-cycle pulse on the last beat of a replay.
- `busy`  out  1  replay in progress.
- `frame_ready`  out  1  N pixels stored.
- `err`  out  1  sticky flag for a dropped write; cleared only by `rst` or `clr`.

## Operation
- Storage: one N×DATA_WIDTH RAM with a synchronous read port, plus a write pointer wp (0..N).
- FSM states:
  - IDLE: `start` with `frame_ready`=1 → STREAM.
  - STREAM: read pointer rp issues one read per cycle; on the last read → DRAIN.
  - DRAIN: one cycle while the final registered beat emits; then → IDLE.
- Write rules:
  - `wr_en` in IDLE with wp<N: RAM[wp] := `wr_data`, wp++.
  - When wp reaches N, `frame_ready` := 1 on the same edge.
  - `wr_en` with wp=N, or in STREAM/DRAIN: write dropped, RAM unchanged, `err` := 1.
- `start` is ignored when `frame_ready`=0 or when not in IDLE.
- `clr` is honoured only in IDLE and wins over a simultaneous `wr_en` (the write is dropped, no `err`). In STREAM/DRAIN, `clr` is ignored.
- The frame is retained after replay: each further `start` replays it identically.
- `busy` = 1 in STREAM and DRAIN.

## Timing
- Reset values: `data_out`=0, `valid_out`=0, `done`=0, `busy`=0, `frame_ready`=0, `err`=0, FSM=IDLE, wp=0, rp=0. RAM contents are not reset.
- `start` sampled at edge k: `busy` goes high after edge k; the first `valid_out` is high after edge k+2 (RAM read + output register).
- `valid_out` stays high for exactly N consecutive cycles (N+4·IMG_W+4·IMG_H+16 with padding), with no bubbles. There is no backpressure.
- `done` is high in the same cycle as the final `valid_out`. `busy` falls on the edge that clears `valid_out`.
- A `start` sampled in the same cycle that `busy` falls is ignored. The earliest accepted restart is one cycle later, i.e. 1 idle cycle between frames minimum.
- `data_out` holds its last value when `valid_out`=0.
- `rst` mid-stream: outputs clear immediately (asynchronous); the stored frame is lost (`frame_ready`=0).

## Configuration
- `FM_STREAM_PAD_EN` defined: each replay emits a (IMG_W+4)×(IMG_H+4) frame with a 2-pixel zero border, so the 5×5 convolution produces a same-size output.
  - Border beats carry `data_out`=0 with `valid_out`=1.
  - Interior beat (r,c), for 2≤r<IMG_H+2 and 2≤c<IMG_W+2, carries RAM[(r-2)·IMG_W+(c-2)].
  - Row and column counters replace rp for sequencing; latency to first beat is unchanged.
- Undefined: no padding logic is present; exactly N beats per replay.

## Test plan
Parameters IMG_W=4, IMG_H=3, DATA_WIDTH=24 unless stated.
- Reset: assert `rst` with random inputs → every output 0; `start` without a stored frame produces no `valid_out`.
- Load/replay: write 0x000001..0x00000C on 12 consecutive cycles → `frame_ready`=1 after the 12th edge. `start` at edge k → `valid_out` high on cycles k+2..k+13 with data 1..12, `done` only on the 12th beat.
- Overrun/ignore: `start` after 5 writes → no stream. A 13th write of 0xABCDEF → `err`=1 and a replay still yields 1..12. A write during STREAM → dropped, `err`=1.
- Replay and clear: second `start` → identical 1..12 sequence. `clr` → `frame_ready`=0, `err`=0; reload 0x100..0x10B → replay yields the new values.
- Reset mid-stream: assert `rst` at beat 5 → `valid_out`/`busy` drop in the same cycle and `frame_ready`=0. After deassert, `start` is ignored.
- `FM_STREAM_PAD_EN`: replay → 56 beats. Beats 0..17 are 0; beat 18 = 0x000001, beat 21 = 0x000004, beats 22..25 are 0, beat 26 = 0x000005. The last 18 beats are 0, and `done` is on beat 55.

Source files
------------

// File: rtl/featuremap_streamer_if.sv
// Pixel-write and replay-stream bundle for featuremap_streamer.
// master = frame producer / stream consumer side, slave = the streamer itself.
interface featuremap_streamer_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  clr;
  logic                  start;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  done;
  logic                  busy;
  logic                  frame_ready;
  logic                  err;

  modport master (
    output wr_en, wr_data, clr, start,
    input  data_out, valid_out, done, busy, frame_ready, err
  );

  modport slave (
    input  wr_en, wr_data, clr, start,
    output data_out, valid_out, done, busy, frame_ready, err
  );
endinterface

// File: rtl/featuremap_streamer.sv
// Frame buffer that stores one IMG_W x IMG_H feature map and replays it as a gap-free raster stream.
// Define FM_STREAM_PAD_EN to wrap every replay in a 2-pixel zero border.
module featuremap_streamer #(
  parameter int DATA_WIDTH = 24,
  parameter int IMG_W      = 12,
  parameter int IMG_H      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  featuremap_streamer_if.slave bus
);
  localparam int N   = IMG_W * IMG_H;
  localparam int AW  = (N > 1) ? $clog2(N) : 1;
  localparam int WPW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [WPW-1:0]        wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic                  frame_ready_q, frame_ready_d;
  logic                  err_q, err_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  done_q, done_d;
  logic                  idle;
  logic                  mem_we;
  logic                  mem_re;

  logic [DATA_WIDTH-1:0] mem [N];
  logic [DATA_WIDTH-1:0] rd_data_q;

`ifdef FM_STREAM_PAD_EN
  localparam int PW = IMG_W + 4;
  localparam int PH = IMG_H + 4;
  localparam int CW = $clog2(PW);
  localparam int RW = $clog2(PH);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          rd_zero_q, rd_zero_d;
  logic          interior;
`endif

  // The final beat is still on the output after the FSM returns to IDLE, so
  // the block only counts as idle once that beat has left.
  assign idle = (state_q == IDLE) && !valid_out_q;

  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    rp_d          = rp_q;
    frame_ready_d = frame_ready_q;
    err_d         = err_q;
    rd_valid_d    = 1'b0;
    rd_last_d     = 1'b0;
    valid_out_d   = rd_valid_q;
    done_d        = rd_last_q;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
`ifdef FM_STREAM_PAD_EN
    col_d         = col_q;
    row_d         = row_q;
    rd_zero_d     = 1'b0;
    interior      = 1'b0;
    data_out_d    = rd_valid_q ? (rd_zero_q ? '0 : rd_data_q) : data_out_q;
`else
    data_out_d    = rd_valid_q ? rd_data_q : data_out_q;
`endif

    if (idle) begin
      if (bus.clr) begin
        wp_d          = '0;
        frame_ready_d = 1'b0;
        err_d         = 1'b0;
      end else if (bus.wr_en) begin
        if (wp_q < WPW'(N)) begin
          mem_we = 1'b1;
          wp_d   = wp_q + WPW'(1);
          if (wp_q == WPW'(N - 1)) frame_ready_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (bus.wr_en) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (idle && bus.start && frame_ready_q && !bus.clr) begin
          state_d = STREAM;
          rp_d    = '0;
`ifdef FM_STREAM_PAD_EN
          col_d   = '0;
          row_d   = '0;
`endif
        end
      end
      STREAM: begin
        rd_valid_d = 1'b1;
`ifdef FM_STREAM_PAD_EN
        interior  = (int'(row_q) >= 2) && (int'(row_q) < IMG_H + 2) &&
                    (int'(col_q) >= 2) && (int'(col_q) < IMG_W + 2);
        mem_re    = interior;
        rd_zero_d = !interior;
        // Interior beats visit the RAM in raster order, so a running address suffices.
        if (interior) rp_d = rp_q + AW'(1);
        if (col_q == CW'(PW - 1)) begin
          col_d = '0;
          if (row_q == RW'(PH - 1)) begin
            row_d     = '0;
            rd_last_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
`else
        mem_re = 1'b1;
        if (rp_q == AW'(N - 1)) begin
          rp_d      = '0;
          rd_last_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          rp_d = rp_q + AW'(1);
        end
`endif
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wp_q[AW-1:0]] <= bus.wr_data;
    if (mem_re) rd_data_q <= mem[rp_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wp_q          <= '0;
      rp_q          <= '0;
      frame_ready_q <= 1'b0;
      err_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      done_q        <= 1'b0;
`ifdef FM_STREAM_PAD_EN
      col_q         <= '0;
      row_q         <= '0;
      rd_zero_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      frame_ready_q <= frame_ready_d;
      err_q         <= err_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      done_q        <= done_d;
`ifdef FM_STREAM_PAD_EN
      col_q         <= col_d;
      row_q         <= row_d;
      rd_zero_q     <= rd_zero_d;
`endif
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != IDLE) || valid_out_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_featuremap_streamer.sv
// Bench for featuremap_streamer: a cycle-window reference model checked every cycle,
// directed load/replay/clear/reset scenarios pinned with literal expectations, then random traffic.
module tb_featuremap_streamer;
  localparam int DW = 24;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
`ifdef FM_STREAM_PAD_EN
  localparam int B  = 56;
`else
  localparam int B  = 12;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  featuremap_streamer_if #(.DATA_WIDTH(DW)) bus ();

  featuremap_streamer #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [DW-1:0] mmem [N];
  logic [DW-1:0] exp_q [$];
  int   cyc = 0;
  int   m_s = -1000;
  int   m_wp = 0;
  bit   m_fr = 0, m_err = 0, m_valid = 0, m_done = 0, m_busy = 0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk or posedge rst) begin
    bit idle_m;
    bit acc;
    if (rst) begin
      m_wp = 0; m_fr = 0; m_err = 0; m_s = -1000;
      m_valid = 0; m_done = 0; m_busy = 0; m_data = '0;
    end else begin
      cyc++;
      idle_m = !m_busy;
      acc = idle_m && bus.start && m_fr && !bus.clr;
      if (idle_m) begin
        if (bus.clr) begin
          m_wp = 0; m_fr = 0; m_err = 0;
        end else if (bus.wr_en) begin
          if (m_wp < N) begin
            mmem[m_wp] = bus.wr_data;
            m_wp++;
            if (m_wp == N) m_fr = 1;
          end else m_err = 1;
        end
      end else if (bus.wr_en) m_err = 1;
      if (acc) begin
        m_s = cyc;
        exp_q.delete();
`ifdef FM_STREAM_PAD_EN
        for (int r = 0; r < H + 4; r++)
          for (int c = 0; c < W + 4; c++)
            if (r >= 2 && r < H + 2 && c >= 2 && c < W + 2) exp_q.push_back(mmem[(r-2)*W + (c-2)]);
            else exp_q.push_back('0);
`else
        for (int i = 0; i < N; i++) exp_q.push_back(mmem[i]);
`endif
      end
      m_busy  = (cyc >= m_s) && (cyc <= m_s + B + 1);
      m_valid = (cyc >= m_s + 2) && (cyc <= m_s + B + 1);
      m_done  = (cyc == m_s + B + 1);
      if (m_valid) m_data = exp_q[cyc - m_s - 2];
    end
  end

  // ---------------- per-cycle compare and beat collector ----------------
  logic [DW-1:0] beats [$];
  int done_cnt = 0;
  int last_done_idx = -1;

  always @(negedge clk) begin
    chk("valid_out",   {31'd0, bus.valid_out},   {31'd0, m_valid});
    chk("done",        {31'd0, bus.done},        {31'd0, m_done});
    chk("busy",        {31'd0, bus.busy},        {31'd0, m_busy});
    chk("frame_ready", {31'd0, bus.frame_ready}, {31'd0, m_fr});
    chk("err",         {31'd0, bus.err},         {31'd0, m_err});
    chk("data_out",    {8'd0, bus.data_out},     {8'd0, m_data});
    if (bus.valid_out) beats.push_back(bus.data_out);
    if (bus.done) begin
      done_cnt++;
      last_done_idx = beats.size() - 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    bus.wr_en = 1'b1; bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic replay(input bit wr_mid, output int base);
    int  dc;
    bit  ok;
    base = beats.size();
    dc = done_cnt;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != dc) begin ok = 1; break; end
      if (wr_mid && i == 3) begin bus.wr_en = 1'b1; bus.wr_data = 24'h555555; end
      else bus.wr_en = 1'b0;
      step();
    end
    bus.wr_en = 1'b0;
    chk("replay_done_seen", {31'd0, ok}, 32'd1);
    step(); step();
  endtask

  task automatic check_frame(input int base, input logic [DW-1:0] first);
    chk("beat_count", beats.size() - base, B);
    chk("done_index", last_done_idx - base, B - 1);
`ifdef FM_STREAM_PAD_EN
    for (int i = 0; i < 18; i++) chk("pad_top", {8'd0, beats[base+i]}, 32'd0);
    chk("pad_beat18", {8'd0, beats[base+18]}, {8'd0, first});
    chk("pad_beat21", {8'd0, beats[base+21]}, {8'd0, first + 24'd3});
    for (int i = 22; i < 26; i++) chk("pad_side", {8'd0, beats[base+i]}, 32'd0);
    chk("pad_beat26", {8'd0, beats[base+26]}, {8'd0, first + 24'd4});
    for (int i = 38; i < 56; i++) chk("pad_bottom", {8'd0, beats[base+i]}, 32'd0);
`else
    for (int i = 0; i < N; i++) chk("beat_value", {8'd0, beats[base+i]}, {8'd0, first + 24'(i)});
`endif
  endtask

  initial begin
    int base;
    int n0;
    bus.wr_en = 0; bus.wr_data = '0; bus.clr = 0; bus.start = 0;
    #1 rst = 1'b1;

    // reset with random inputs: outputs must stay 0
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'($urandom); bus.wr_data = 24'($urandom);
      bus.clr = 1'($urandom); bus.start = 1'($urandom);
      step();
      chk("rst_data_out",    {8'd0, bus.data_out}, 32'd0);
      chk("rst_valid_out",   {31'd0, bus.valid_out}, 32'd0);
      chk("rst_done",        {31'd0, bus.done}, 32'd0);
      chk("rst_busy",        {31'd0, bus.busy}, 32'd0);
      chk("rst_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
      chk("rst_err",         {31'd0, bus.err}, 32'd0);
    end
    bus.wr_en = 0; bus.clr = 0; bus.start = 0;
    rst = 1'b0;
    step();

    // start with no frame
    bus.start = 1; step(); bus.start = 0;
    for (int i = 0; i < 6; i++) step();
    chk("no_frame_no_stream", beats.size(), 0);

    // load 1..12 and replay
    for (int i = 1; i <= N; i++) begin
      chk("fr_before_full", {31'd0, bus.frame_ready}, 32'd0);
      wr(24'(i));
    end
    chk("fr_after_12", {31'd0, bus.frame_ready}, 32'd1);
    replay(0, base);
    check_frame(base, 24'd1);

    // partial frame: start ignored, then overrun
    bus.clr = 1; step(); bus.clr = 0;
    for (int i = 1; i <= 5; i++) wr(24'(i));
    n0 = beats.size();
    bus.start = 1; step(); bus.start = 0;
    for (int i = 0; i < 6; i++) step();
    chk("partial_no_stream", beats.size(), n0);
    for (int i = 6; i <= N; i++) wr(24'(i));
    chk("err_before_overrun", {31'd0, bus.err}, 32'd0);
    wr(24'hABCDEF);
    chk("err_after_overrun", {31'd0, bus.err}, 32'd1);
    replay(0, base);
    check_frame(base, 24'd1);

    // write during stream dropped, second replay identical
    bus.clr = 1; step(); bus.clr = 0;
    for (int i = 1; i <= N; i++) wr(24'(i));
    replay(1, base);
    chk("err_after_stream_write", {31'd0, bus.err}, 32'd1);
    check_frame(base, 24'd1);
    replay(0, base);
    check_frame(base, 24'd1);

    // clear and reload
    bus.clr = 1; step(); bus.clr = 0;
    chk("clr_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
    chk("clr_err", {31'd0, bus.err}, 32'd0);
    for (int i = 0; i < N; i++) wr(24'h100 + 24'(i));
    replay(0, base);
    check_frame(base, 24'h100);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_data = 24'($urandom);
      bus.clr     = ($urandom_range(0, 96) == 0);
      bus.start   = ($urandom_range(0, 16) == 0);
      step();
    end
    bus.wr_en = 0; bus.clr = 0; bus.start = 0;
    for (int i = 0; i < 80; i++) step();

    // reset mid-stream
    bus.clr = 1; step(); bus.clr = 0;
    for (int i = 1; i <= N; i++) wr(24'(i));
    base = beats.size();
    bus.start = 1; step(); bus.start = 0;
    for (int i = 0; i < 80 && beats.size() < base + 5; i++) step();
    chk("mid_reached_beat5", beats.size() - base, 5);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    n0 = beats.size();
    bus.start = 1; step(); bus.start = 0;
    for (int i = 0; i < 8; i++) step();
    chk("post_rst_no_stream", beats.size(), n0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
